bsg_reset_sequencer: RTL and testbench
======================================

BSG_RESET_SEQUENCER -- requirements
Module: bsg_reset_sequencer

Interface
REQ-001 SHALL have parameter sync_stages_p, default 2: number of synchronizer flops on reset deassertion; must be >= 2.
REQ-002 SHALL have parameter stages_p, default 4: number of staged reset outputs; must be >= 1.
REQ-003 SHALL have parameter hold_cycles_p, default 16: clock cycles between consecutive stage releases; must be >= 1.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port async_reset_n_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port soft_reset_i, input, 1: synchronous restart request; present only with the macro defined.
REQ-007 SHALL have port reset_o, output, stages_p: active-high per-stage resets that drive downstream async-reset flops; bit 0 releases first.
REQ-008 SHALL have port ready_o, output, 1: high when all stages are released.

Function
REQ-009 SHALL deassert async_reset_n_i through sync_stages_p flops: assertion is asynchronous, deassertion is synchronous.
REQ-010 SHALL implement an FSM with states eRESET, eCOUNT and eDONE.
REQ-011 eRESET SHALL move to eCOUNT on the first edge that samples the synchronized reset as released; on that edge counter=0 and stage index=0.
REQ-012 In eCOUNT the counter SHALL increment each edge.
REQ-013 When counter==hold_cycles_p-1, the next edge SHALL clear reset_o[idx], increment idx and zero the counter.
REQ-014 The edge that clears reset_o[stages_p-1] SHALL enter eDONE and set ready_o=1 on that same edge.
REQ-015 Release timing: counting the first rising edge after deassertion as edge 1, reset_o[k] SHALL fall at edge sync_stages_p+1+hold_cycles_p*(k+1).
REQ-016 reset_o SHALL be thermometer-coded at all times: a bit never releases before all lower bits are released.
REQ-017 Counter width SHALL be $clog2(hold_cycles_p+1) and the counter SHALL never wrap.
REQ-018 stage index width SHALL be $clog2(stages_p+1).
REQ-019 In eDONE the outputs SHALL hold until reset or soft reset.
REQ-020 Assertion of async_reset_n_i in any state, including mid-count, SHALL abort the sequence; a restart SHALL always begin from stage 0.
REQ-021 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-022 While async_reset_n_i=0, outputs SHALL be reset_o = all ones, ready_o=0, state eRESET, counter 0 and idx 0.
REQ-023 Those values SHALL take effect immediately, with no clock edge required.
REQ-024 Any low pulse on async_reset_n_i, however short, SHALL fully reassert all outputs.

Configuration
REQ-025 SHALL use macro BSG_RESET_SEQUENCER_SOFT_RESET_EN.
REQ-026 When the macro is defined, soft_reset_i=1 sampled in eDONE SHALL, on that edge E, set reset_o to all ones and ready_o=0, and enter eCOUNT with counter 0 and idx 0; reset_o[k] then falls at E+hold_cycles_p*(k+1).
REQ-027 When the macro is defined, soft_reset_i SHALL be ignored in eRESET and eCOUNT.
REQ-028 When the macro is undefined, the soft_reset_i port and the soft-reset logic SHALL be absent.

Structure
REQ-029 Package bsg_reset_sequencer_pkg SHALL hold the FSM state enum (eRESET, eCOUNT, eDONE).
REQ-030 Sub-module bsg_reset_sequencer_sync SHALL implement the sync_stages_p-deep async-assert/sync-deassert synchronizer; the top level instantiates it once.
REQ-031 All state flops SHALL be asynchronously reset by async_reset_n_i.

Verification
REQ-032 Defaults, async_reset_n_i deasserted before edge 1 -> reset_o falls bit-by-bit at edges 19, 35, 51 and 67; ready_o rises at edge 67; outputs are stable afterwards.
REQ-033 Defaults, async_reset_n_i pulsed low between edges 40 and 41 -> reset_o=4'b1111 and ready_o=0 before edge 41; after the pulse ends the sequence restarts with identical relative timing.
REQ-034 sync_stages_p=2, stages_p=1, hold_cycles_p=1 -> reset_o[0] and ready_o change at edge 4.
REQ-035 With the macro defined, a soft_reset_i pulse at edge 100 in eDONE -> at edge 100 reset_o=4'b1111 and ready_o=0; releases occur at edges 116, 132, 148 and 164.
REQ-036 With the macro defined, soft_reset_i held high during eCOUNT -> no effect; timing is as in REQ-032.
REQ-037 Every cycle -> assertion checks that reset_o is thermometer-coded and that ready_o equals ~reset_o[stages_p-1].

Source files
------------

// File: rtl/bsg_reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// bsg_reset_sequencer_pkg : shared FSM state encoding for the reset sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bsg_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    eRESET = 2'd0,
    eCOUNT = 2'd1,
    eDONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_reset_sequencer_sync.sv
// ---------------------------------------------------------------------------
// bsg_reset_sequencer_sync : async-assert / sync-deassert reset synchronizer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_reset_sequencer_sync #(
  parameter int sync_stages_p = 2
) (
  input  logic clk_i,
  input  logic async_reset_n_i,
  output logic sync_reset_n_o
);

  logic [sync_stages_p-1:0] r_sync;

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[sync_stages_p-2:0], 1'b1};
    end
  end

  assign sync_reset_n_o = r_sync[sync_stages_p-1];

endmodule

`default_nettype wire

// File: rtl/bsg_reset_sequencer.sv
// ---------------------------------------------------------------------------
// bsg_reset_sequencer : staged, thermometer-coded reset release sequencer.
// Optional soft restart from eDONE: macro BSG_RESET_SEQUENCER_SOFT_RESET_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_reset_sequencer
  import bsg_reset_sequencer_pkg::*;
#(
  parameter int sync_stages_p = 2,
  parameter int stages_p      = 4,
  parameter int hold_cycles_p = 16
) (
  input  logic                clk_i,
  input  logic                async_reset_n_i,
`ifdef BSG_RESET_SEQUENCER_SOFT_RESET_EN
  input  logic                soft_reset_i,
`endif
  output logic [stages_p-1:0] reset_o,
  output logic                ready_o
);

  localparam int unsigned c_CNT_W = $clog2(hold_cycles_p + 1);
  localparam int unsigned c_IDX_W = $clog2(stages_p + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(hold_cycles_p - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(stages_p - 1);

  generate
    if (sync_stages_p < 2) begin : g_bad_sync_stages
      $error("bsg_reset_sequencer: sync_stages_p must be >= 2");
    end
    if (stages_p < 1) begin : g_bad_stages
      $error("bsg_reset_sequencer: stages_p must be >= 1");
    end
    if (hold_cycles_p < 1) begin : g_bad_hold_cycles
      $error("bsg_reset_sequencer: hold_cycles_p must be >= 1");
    end
  endgenerate

  logic                w_sync_reset_n;
  state_e              r_state,  w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [c_IDX_W-1:0]  r_idx,    w_idx_nxt;
  logic [stages_p-1:0] r_reset,  w_reset_nxt;
  logic                r_ready,  w_ready_nxt;

  bsg_reset_sequencer_sync #(
    .sync_stages_p (sync_stages_p)
  ) u_sync (
    .clk_i           (clk_i),
    .async_reset_n_i (async_reset_n_i),
    .sync_reset_n_o  (w_sync_reset_n)
  );

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      r_state <= eRESET;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_reset <= '1;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_reset <= w_reset_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_reset_nxt = r_reset;
    w_ready_nxt = r_ready;
    case (r_state)
      eRESET: begin
        if (w_sync_reset_n) begin
          w_state_nxt = eCOUNT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      eCOUNT: begin
        if (r_cnt == c_CNT_LAST) begin
          // Shifting a zero in from the bottom keeps the vector thermometer-coded.
          w_reset_nxt = r_reset << 1;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 1'b1;
          if (r_idx == c_IDX_LAST) begin
            w_state_nxt = eDONE;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      eDONE: begin
`ifdef BSG_RESET_SEQUENCER_SOFT_RESET_EN
        if (soft_reset_i) begin
          w_state_nxt = eCOUNT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_reset_nxt = '1;
          w_ready_nxt = 1'b0;
        end
`endif
      end
      default: begin
        w_state_nxt = eRESET;
      end
    endcase
  end

  assign reset_o = r_reset;
  assign ready_o = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_bsg_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bsg_reset_sequencer : directed self-checking bench for the reset sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bsg_reset_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
`ifdef BSG_RESET_SEQUENCER_SOFT_RESET_EN
  logic       soft  = 1'b0;
  logic       soft_b = 1'b0;
`endif
  logic [3:0] a_reset;
  logic       a_ready;
  logic [0:0] b_reset;
  logic       b_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_reset_sequencer u_dut_a (
    .clk_i           (clk),
    .async_reset_n_i (rst_n),
`ifdef BSG_RESET_SEQUENCER_SOFT_RESET_EN
    .soft_reset_i    (soft),
`endif
    .reset_o         (a_reset),
    .ready_o         (a_ready)
  );

  bsg_reset_sequencer #(
    .sync_stages_p (2),
    .stages_p      (1),
    .hold_cycles_p (1)
  ) u_dut_b (
    .clk_i           (clk),
    .async_reset_n_i (rst_n),
`ifdef BSG_RESET_SEQUENCER_SOFT_RESET_EN
    .soft_reset_i    (soft_b),
`endif
    .reset_o         (b_reset),
    .ready_o         (b_ready)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Default build: bit k falls at edge 2+1+16*(k+1).
  function automatic logic [3:0] exp_a_reset(input int e);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (e < 3 + 16 * (k + 1));
    return r;
  endfunction

  task automatic run_seq(input int n);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      chk_eq($sformatf("a_reset@%0d", e), {28'd0, a_reset}, {28'd0, exp_a_reset(e)});
      chk_eq($sformatf("a_ready@%0d", e), {31'd0, a_ready}, {31'd0, (e >= 67)});
      chk_eq($sformatf("b_reset@%0d", e), {31'd0, b_reset}, {31'd0, (e < 4)});
      chk_eq($sformatf("b_ready@%0d", e), {31'd0, b_ready}, {31'd0, (e >= 4)});
`ifdef BSG_RESET_SEQUENCER_SOFT_RESET_EN
      if (e == 67) soft = 1'b0;
`endif
    end
  endtask

  task automatic chk_all_reset(input string tag);
    chk_eq({tag, "_a_reset"}, {28'd0, a_reset}, 32'hF);
    chk_eq({tag, "_a_ready"}, {31'd0, a_ready}, 32'h0);
    chk_eq({tag, "_b_reset"}, {31'd0, b_reset}, 32'h1);
    chk_eq({tag, "_b_ready"}, {31'd0, b_ready}, 32'h0);
  endtask

  // Every-cycle invariants: thermometer shape and ready tracking the top stage.
  always @(negedge clk) begin
    logic [3:0] inv;
    logic [3:0] thermo;
    logic       a_top_n;
    logic       b_top_n;
    inv     = ~a_reset;
    thermo  = inv & (inv + 4'd1);
    a_top_n = ~a_reset[3];
    b_top_n = ~b_reset[0];
    chk_eq("thermo_a", {28'd0, thermo}, 32'h0);
    chk_eq("ready_vs_top_a", {31'd0, a_ready}, {31'd0, a_top_n});
    chk_eq("ready_vs_top_b", {31'd0, b_ready}, {31'd0, b_top_n});
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_reset("in_reset");

    @(negedge clk) rst_n = 1'b1;
    run_seq(80);

    // Short pulse after completion: immediate reassertion, then full restart.
    #2 rst_n = 1'b0;
    #1 chk_all_reset("async_from_done");
    #1 rst_n = 1'b1;
    run_seq(40);

    // Abort mid-count between edges 40 and 41.
    #2 rst_n = 1'b0;
    #1 chk_all_reset("async_mid_count");
    #1 rst_n = 1'b1;
`ifdef BSG_RESET_SEQUENCER_SOFT_RESET_EN
    soft = 1'b1;
`endif
    run_seq(80);

`ifdef BSG_RESET_SEQUENCER_SOFT_RESET_EN
    @(negedge clk) soft = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("soft_edge_reset", {28'd0, a_reset}, 32'hF);
    chk_eq("soft_edge_ready", {31'd0, a_ready}, 32'h0);
    @(negedge clk) soft = 1'b0;
    for (int j = 1; j <= 70; j++) begin
      logic [3:0] er;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) er[k] = (j < 16 * (k + 1));
      chk_eq($sformatf("soft_reset@+%0d", j), {28'd0, a_reset}, {28'd0, er});
      chk_eq($sformatf("soft_ready@+%0d", j), {31'd0, a_ready}, {31'd0, (j >= 64)});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
